spi_arb: RTL and testbench

- Shares the single SPI master between two requesters.
  - Requester 0: inertial interface state machine, which issues a one-cycle wrt, a 16-bit cmd, then waits for done.
  - Requester 1: A2D/battery monitor.
- Buffers one pending command per requester and grants the master round-robin.
- Returns the master's done and read data to the owning requester only.
- Sits between the requester state machines and the SPI master.

---
 rtl/spi_arb_pkg.sv | 15 +
 rtl/spi_arb_req_buf.sv | 46 ++++
 rtl/spi_arb.sv | 148 ++++++++++++++
 tb/tb_spi_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI master arbiter.
package spi_arb_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TMO_CYC_DEF = 4096;

    // Requester identifiers; also the encoding of owner / last_grant.
    localparam logic REQ_INRT = 1'b0;
    localparam logic REQ_A2D  = 1'b1;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t BUSY = 1'b1;

endpackage

// File: rtl/spi_arb_req_buf.sv
// One-deep command buffer for a single requester. The strobe and command are
// registered on entry, then held as a pending request until the arbiter
// grants it. A new strobe overwrites an ungranted command and wins over a
// same-cycle clear, so a request arriving on the grant edge is not lost.
import spi_arb_pkg::*;

module spi_arb_req_buf #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic              clr,
    output logic              pend,
    output logic [DATA_W-1:0] cmdq
);

    logic              wrt_q;
    logic [DATA_W-1:0] cmd_q;

    // Input sampling stage for the requester strobe and command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrt_q <= 1'b0;
            cmd_q <= '0;
        end else begin
            wrt_q <= wrt;
            cmd_q <= wrt ? cmd : cmd_q;
        end
    end

    // Pending flag and held command; capture takes priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            cmdq <= '0;
        end else if (wrt_q) begin
            pend <= 1'b1;
            cmdq <= cmd_q;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between the inertial interface
// (requester 0) and the A2D monitor (requester 1). Completion, read data and
// timeout status are routed back only to the requester that owns the transfer.
//
//   state | meaning
//   IDLE  | no transfer outstanding; grants a pending request if any
//   BUSY  | wrt_m issued, waiting for done_m or the timeout
import spi_arb_pkg::*;

module spi_arb #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt0,
    input  logic [DATA_W-1:0] cmd0,
    output logic              done0,
    output logic [DATA_W-1:0] rd0,
    output logic              err0,
    input  logic              wrt1,
    input  logic [DATA_W-1:0] cmd1,
    output logic              done1,
    output logic [DATA_W-1:0] rd1,
    output logic              err1,
    output logic              wrt_m,
    output logic [DATA_W-1:0] cmd_m,
    input  logic              done_m,
    input  logic [DATA_W-1:0] rd_m,
    output logic              busy
);

    localparam int TMR_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic [TMR_W-1:0]  timer;
    logic              pend0;
    logic              pend1;
    logic [DATA_W-1:0] cmdq0;
    logic [DATA_W-1:0] cmdq1;
    logic              clr0;
    logic              clr1;
    logic              gnt_vld;
    logic              gnt_id;
    logic              done_q;
    logic [DATA_W-1:0] rd_q;
    logic              fin;

    spi_arb_req_buf #(.DATA_W(DATA_W)) u_buf0 (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt0),
        .cmd  (cmd0),
        .clr  (clr0),
        .pend (pend0),
        .cmdq (cmdq0)
    );

    spi_arb_req_buf #(.DATA_W(DATA_W)) u_buf1 (
        .clk  (clk),
        .rst  (rst),
        .wrt  (wrt1),
        .cmd  (cmd1),
        .clr  (clr1),
        .pend (pend1),
        .cmdq (cmdq1)
    );

    // Grant selection: a lone request wins outright, a tie goes to the
    // requester that was not served last.
    always_comb begin
        gnt_vld = (state == IDLE) && (pend0 || pend1);
        gnt_id  = (pend0 && pend1) ? ~last_grant : pend1;
        clr0    = gnt_vld && (gnt_id == REQ_INRT);
        clr1    = gnt_vld && (gnt_id == REQ_A2D);
        fin     = (state == BUSY) && (done_q || (timer == TMR_LAST));
    end

    // Sampling stage for the SPI master completion and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            rd_q   <= '0;
        end else begin
            done_q <= done_m;
            rd_q   <= rd_m;
        end
    end

    // Transfer state machine, timeout timer and routed requester outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= REQ_INRT;
            last_grant <= REQ_A2D;
            timer      <= '0;
            wrt_m      <= 1'b0;
            cmd_m      <= '0;
            busy       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rd0        <= '0;
            rd1        <= '0;
        end else begin
            wrt_m <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        wrt_m <= 1'b1;
                        cmd_m <= (gnt_id == REQ_A2D) ? cmdq1 : cmdq0;
                        owner <= gnt_id;
                        busy  <= 1'b1;
                        timer <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (fin) begin
                        // A completion arriving on the timeout cycle still counts as good.
                        if (owner == REQ_A2D) begin
                            done1 <= 1'b1;
                            err1  <= ~done_q;
                            if (done_q) rd1 <= rd_q;
                        end else begin
                            done0 <= 1'b1;
                            err0  <= ~done_q;
                            if (done_q) rd0 <= rd_q;
                        end
                        last_grant <= owner;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: stimulus pushes expected strobes/completions
// (with the cycle they must appear) into queues; a monitor pops and compares.
module tb_spi_arb;

    localparam int DW  = 16;
    localparam int TMO = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wrt0 = 1'b0, wrt1 = 1'b0, done_m = 1'b0;
    logic [DW-1:0] cmd0 = '0, cmd1 = '0, rd_m = '0;
    logic          done0, done1, err0, err1, wrt_m, busy;
    logic [DW-1:0] rd0, rd1, cmd_m;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            at;
    } exp_t;

    exp_t q_wrt[$];
    exp_t q_d0[$];
    exp_t q_d1[$];
    exp_t e;

    spi_arb #(.DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .wrt0(wrt0), .cmd0(cmd0), .done0(done0), .rd0(rd0), .err0(err0),
        .wrt1(wrt1), .cmd1(cmd1), .done1(done1), .rd1(rd1), .err1(err1),
        .wrt_m(wrt_m), .cmd_m(cmd_m), .done_m(done_m), .rd_m(rd_m), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe/done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (wrt_m) begin
            checks++;
            if (q_wrt.size() == 0) begin
                errors++;
                $display("FAIL wrt_m_unexpected: got cmd_m=%h at cyc %0d, required no strobe", cmd_m, cyc);
            end else begin
                e = q_wrt.pop_front();
                if (cmd_m !== e.data || cyc != e.at) begin
                    errors++;
                    $display("FAIL wrt_m: got cmd_m=%h cyc=%0d, required cmd_m=%h cyc=%0d", cmd_m, cyc, e.data, e.at);
                end
            end
        end else if (q_wrt.size() > 0 && cyc > q_wrt[0].at) begin
            e = q_wrt.pop_front();
            checks++; errors++;
            $display("FAIL wrt_m_missing: got none by cyc %0d, required cmd_m=%h at cyc %0d", cyc, e.data, e.at);
        end

        if (done0) begin
            checks++;
            if (q_d0.size() == 0) begin
                errors++;
                $display("FAIL done0_unexpected: got done0 at cyc %0d, required none", cyc);
            end else begin
                e = q_d0.pop_front();
                if (rd0 !== e.data || err0 !== e.err || cyc != e.at) begin
                    errors++;
                    $display("FAIL done0: got rd0=%h err0=%b cyc=%0d, required rd0=%h err0=%b cyc=%0d", rd0, err0, cyc, e.data, e.err, e.at);
                end
            end
        end else if (q_d0.size() > 0 && cyc > q_d0[0].at) begin
            e = q_d0.pop_front();
            checks++; errors++;
            $display("FAIL done0_missing: got none by cyc %0d, required at cyc %0d", cyc, e.at);
        end

        if (done1) begin
            checks++;
            if (q_d1.size() == 0) begin
                errors++;
                $display("FAIL done1_unexpected: got done1 at cyc %0d, required none", cyc);
            end else begin
                e = q_d1.pop_front();
                if (rd1 !== e.data || err1 !== e.err || cyc != e.at) begin
                    errors++;
                    $display("FAIL done1: got rd1=%h err1=%b cyc=%0d, required rd1=%h err1=%b cyc=%0d", rd1, err1, cyc, e.data, e.err, e.at);
                end
            end
        end else if (q_d1.size() > 0 && cyc > q_d1[0].at) begin
            e = q_d1.pop_front();
            checks++; errors++;
            $display("FAIL done1_missing: got none by cyc %0d, required at cyc %0d", cyc, e.at);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    // Drive one requester strobe for a cycle; optionally expect its wrt_m 3 negedges on.
    task automatic issue(input int id, input logic [DW-1:0] c, input bit expect_now);
        if (id == 0) begin wrt0 = 1'b1; cmd0 = c; end
        else         begin wrt1 = 1'b1; cmd1 = c; end
        if (expect_now) q_wrt.push_back('{c, 1'b0, cyc + 3});
        tick();
        wrt0 = 1'b0; wrt1 = 1'b0;
    endtask

    task automatic wait_wrt();
        int n = 0;
        while (!wrt_m && n < 200) begin tick(); n++; end
        if (!wrt_m) begin
            checks++; errors++;
            $display("FAIL wait_wrt_m: got no strobe within 200 cycles, required a strobe");
        end
    endtask

    // Pulse done_m now; expect the owner's done two negedges later, and the
    // next grant (if any) one cycle after that.
    task automatic respond(input int id, input logic [DW-1:0] rd, input bit nxt, input logic [DW-1:0] ncmd);
        done_m = 1'b1; rd_m = rd;
        if (id == 0) q_d0.push_back('{rd, 1'b0, cyc + 2});
        else         q_d1.push_back('{rd, 1'b0, cyc + 2});
        if (nxt) q_wrt.push_back('{ncmd, 1'b0, cyc + 3});
        tick();
        done_m = 1'b0; rd_m = '0; wrt0 = 1'b0; wrt1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        do_reset();
        chk("rst_wrt_m", {15'd0, wrt_m}, 16'd0);
        chk("rst_cmd_m", cmd_m, 16'd0);
        chk("rst_busy",  {15'd0, busy}, 16'd0);
        chk("rst_rd0",   rd0, 16'd0);
        chk("rst_rd1",   rd1, 16'd0);
        chk("rst_flags", {12'd0, done0, done1, err0, err1}, 16'd0);

        // Single request from requester 0.
        issue(0, 16'h0D02, 1'b1);
        wait_wrt();
        chk("single_busy", {15'd0, busy}, 16'd1);
        repeat (3) tick();
        respond(0, 16'h00A5, 1'b0, '0);
        repeat (3) tick();
        chk("single_rd0",  rd0, 16'h00A5);
        chk("single_err0", {15'd0, err0}, 16'd0);
        chk("single_busy_low", {15'd0, busy}, 16'd0);

        // Tie after reset: 0 first, then 1; repeat the tie, 0 first again.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            wrt0 = 1'b1; cmd0 = 16'hA200; wrt1 = 1'b1; cmd1 = 16'h1234;
            q_wrt.push_back('{16'hA200, 1'b0, cyc + 3});
            tick();
            wrt0 = 1'b0; wrt1 = 1'b0;
            wait_wrt();
            tick();
            respond(0, 16'h1111, 1'b1, 16'h1234);
            wait_wrt();
            tick();
            respond(1, 16'h2222, 1'b0, '0);
            repeat (3) tick();
        end
        chk("tie_rd1", rd1, 16'h2222);

        // Back-to-back: requester 1 waits behind 0; 0 re-requests with its done_m.
        issue(0, 16'h0B01, 1'b1);
        wait_wrt();
        tick();
        issue(1, 16'h1B02, 1'b0);
        repeat (4) tick();
        wrt0 = 1'b1; cmd0 = 16'h0B03;
        respond(0, 16'h3333, 1'b1, 16'h1B02);
        wait_wrt();
        repeat (2) tick();
        respond(1, 16'h4444, 1'b1, 16'h0B03);
        wait_wrt();
        tick();
        respond(0, 16'h5555, 1'b0, '0);
        repeat (3) tick();
        chk("b2b_rd1", rd1, 16'h4444);

        // Timeout: no done_m; done0 with err0 exactly TMO cycles after wrt_m.
        issue(0, 16'h0C0C, 1'b1);
        wait_wrt();
        q_d0.push_back('{16'h5555, 1'b1, cyc + TMO});
        n = 0;
        while (!done0 && n < TMO + 50) begin tick(); n++; end
        chk("tmo_busy", {15'd0, busy}, 16'd0);
        tick();
        done_m = 1'b1; rd_m = 16'hDEAD;
        tick();
        done_m = 1'b0; rd_m = '0;
        repeat (5) tick();
        chk("tmo_err0_held", {15'd0, err0}, 16'd1);
        chk("tmo_rd0_held",  rd0, 16'h5555);

        // Overwrite: requester 1 rewrites its command while 0 is busy.
        issue(0, 16'h0E0E, 1'b1);
        wait_wrt();
        tick();
        issue(1, 16'h1053, 1'b0);
        issue(1, 16'h1150, 1'b0);
        repeat (3) tick();
        respond(0, 16'h6666, 1'b1, 16'h1150);
        chk("ovw_err0_at_done", {15'd0, err0}, 16'd1);
        wait_wrt();
        tick();
        respond(1, 16'h7777, 1'b0, '0);
        repeat (3) tick();
        chk("ovw_rd0", rd0, 16'h6666);
        chk("ovw_err0_clear", {15'd0, err0}, 16'd0);
        chk("ovw_rd1", rd1, 16'h7777);

        // Reset mid-transfer with requester 1 pending; late done_m ignored.
        issue(0, 16'h0D0D, 1'b1);
        wait_wrt();
        tick();
        issue(1, 16'h1D0D, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        chk("mid_rst_cmd_m", cmd_m, 16'd0);
        chk("mid_rst_rd", rd0 | rd1, 16'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        done_m = 1'b1; rd_m = 16'hBEEF;
        tick();
        done_m = 1'b0; rd_m = '0;
        repeat (12) tick();
        chk("mid_rst_after", {11'd0, busy, done0, done1, err0, err1}, 16'd0);

        chk("queues_empty", 16'(q_wrt.size() + q_d0.size() + q_d1.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion by time limit, required bench to finish");
        $fatal(1);
    end

endmodule
